nios2_debug_ocimem_ctrl: RTL and testbench
==========================================

# nios2_debug_ocimem_ctrl

Sysclk-domain on-chip debug memory controller that sits directly downstream of the CPU debug-slave wrapper. It consumes the decoded JTAG strobes (`take_action_ocimem_a`, `take_action_ocimem_b`, `take_no_action_ocimem_a`) and the 38-bit `jdo` payload. It executes address-load, read and write commands against an internal debug RAM, and returns `MonDReg`, `monitor_ready` and `monitor_error` to the wrapper. A read-only CPU port gives the Nios II core access to the same RAM; debug accesses have priority.

## Interface
- `ADDR_W`, 8: word-address width; RAM depth = 2^ADDR_W 32-bit words.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `jdo` in 38: JTAG payload from the debug slave, stable while any strobe is high.
- `take_action_ocimem_a` in 1: one-cycle strobe; load address.
- `take_no_action_ocimem_a` in 1: one-cycle strobe; read at current address, then post-increment.
- `take_action_ocimem_b` in 1: one-cycle strobe; write at current address, then post-increment.
- `MonDReg` out 32: last debug read data.
- `monitor_ready` out 1: controller idle and able to accept a strobe.
- `monitor_error` out 1: sticky command error.
- `cpu_address` in ADDR_W: CPU word address.
- `cpu_read` in 1: CPU read request, held until accepted.
- `cpu_waitrequest` out 1: CPU request not accepted this cycle.
- `cpu_readdata` out 32: CPU read data.
- `cpu_readdatavalid` out 1: `cpu_readdata` valid this cycle.

## Operation
- The RAM is single-port and synchronous: address and write-enable are registered on the edge, and read data is available the following cycle. RAM contents are not reset.
- The address register `mon_addr` is ADDR_W bits.
- `take_action_ocimem_a`:
  - If `jdo[36]`=0: `mon_addr <= jdo[ADDR_W+1:2]` (byte bits 1:0 ignored), and `monitor_error` clears.
  - If `jdo[35]`=1 as well: an immediate read of the new address is launched the next cycle, with no increment.
  - If `jdo[36]`=1: reserved; `mon_addr` is unchanged and `monitor_error` is set.
- `take_no_action_ocimem_a`: read RAM[`mon_addr`] into `MonDReg`, then `mon_addr <= mon_addr+1`.
- `take_action_ocimem_b`: write `jdo[34:3]` to RAM[`mon_addr`], then `mon_addr <= mon_addr+1`. Single-cycle; `monitor_ready` stays 1.
- `mon_addr` increment wraps modulo 2^ADDR_W: 2^ADDR_W−1 → 0.
- FSM states:
  - IDLE → RD on a read strobe, or on an address load with `jdo[35]`=1.
  - RD → CAP (RAM output settling).
  - CAP → IDLE: `MonDReg` is captured on the edge leaving CAP, and the increment happens on the same edge (increment suppressed for the address-load read).
- Strobe while not IDLE: ignored, `monitor_error` <= 1, no RAM or address side effect.
- Strobes asserted simultaneously: priority is ocimem_a > ocimem_b > no_action_ocimem_a; the losers are dropped without error.
- CPU port:
  - `cpu_waitrequest` = `cpu_read` & (any debug strobe this cycle | state != IDLE). This is combinational.
  - An accepted CPU read drives `cpu_readdatavalid`=1 exactly two cycles later.
  - CPU reads never modify `mon_addr` or `MonDReg`.
- Reset values: `MonDReg`=0, `mon_addr`=0, `monitor_ready`=1, `monitor_error`=0, `cpu_readdatavalid`=0, `cpu_readdata`=0, FSM=IDLE.
- Reset mid-read aborts the read: no `MonDReg` update, no increment, and pending `cpu_readdatavalid` is cleared.

## Timing
- Debug read, strobe in cycle N (IDLE):
  - N+1: RD, `monitor_ready`=0.
  - N+2: CAP, `monitor_ready`=0.
  - N+3: IDLE, `monitor_ready`=1, new `MonDReg` and incremented `mon_addr` visible.
- Debug write, strobe in cycle N: RAM and `mon_addr` update on the edge ending N. A read strobe in N+1 returns the written data.
- Address load in N: new `mon_addr` visible in N+1.
- `monitor_ready` is registered: it falls in the cycle after an accepted read strobe and is never low for a write.
- CPU read accepted in N (`cpu_read`=1, `cpu_waitrequest`=0): `cpu_readdatavalid`=1 with data in N+2, for one cycle only. Back-to-back accepted reads give one valid per cycle.
- Collision: a CPU read coincident with a debug strobe, or during RD/CAP, stalls. It is accepted in the first cycle the FSM is IDLE with no strobe present.

## Test plan
- Write then read back:
  - ocimem_a with addr byte 0x010 (word 4), then ocimem_b with `jdo[34:3]`=0xDEADBEEF.
  - ocimem_a to word 4 again, then no_action read.
  - Expect `MonDReg`=0xDEADBEEF at N+3, `mon_addr`=5, `monitor_error`=0.
- Wrap-around:
  - Load word 255 (ADDR_W=8), then write 0x11111111 followed by a write of 0x22222222.
  - Read words 255 and 0: expect 0x11111111 and 0x22222222 respectively.
- Busy error:
  - Issue a read strobe, then another read strobe one cycle later.
  - Expect `monitor_error`=1, the second read ignored and `mon_addr` incremented once.
  - A following ocimem_a with `jdo[36]`=0 clears the error.
- Reserved bit: ocimem_a with `jdo[36]`=1 → `monitor_error`=1, `mon_addr` unchanged.
- CPU arbitration:
  - Hold `cpu_read` at word 4 while issuing a debug read.
  - Expect `cpu_waitrequest`=1 through CAP, acceptance the first IDLE cycle after, then `cpu_readdatavalid`=1 two cycles later with 0xDEADBEEF.
  - `MonDReg` is unaffected.
- Reset mid-read: assert `reset` in the RD cycle → next cycle FSM IDLE, `monitor_ready`=1, `MonDReg`=0, `mon_addr`=0, no `cpu_readdatavalid`.

Source files
------------

// File: rtl/nios2_debug_ocimem_ctrl.sv
// On-chip debug memory controller: executes JTAG address-load/read/write strobes
// against a single-port debug RAM shared with a read-only CPU port.
//
// state | meaning
// IDLE  | ready for a debug strobe; CPU reads may be accepted
// RD    | RAM addressed with mon_addr for a debug read
// CAP   | RAM output settling; MonDReg captured on the edge leaving
module nios2_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  output logic              cpu_waitrequest,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_readdatavalid
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP} state_t;

  state_t              r_state, w_next_state;
  logic [ADDR_W-1:0]   r_mon_addr;
  logic                r_error;
  logic                r_no_inc;
  logic [31:0]         r_mon_dreg;
  logic [31:0]         r_ram_q;
  logic [31:0]         r_mem [0:(1<<ADDR_W)-1];
  logic                r_cpu_pend;
  logic                r_cpu_valid;
  logic [31:0]         r_cpu_rdata;

  logic                w_idle;
  logic                w_any_strobe;
  logic                w_ld_ok;
  logic                w_ld_rsvd;
  logic                w_ld_rd;
  logic                w_wr;
  logic                w_rd;
  logic                w_busy_err;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic                w_cpu_accept;
  logic                w_unused;

  assign w_unused = ^{jdo[37], jdo[1:0]};

  // Command decode: ocimem_a beats ocimem_b beats the read strobe, only in IDLE.
  assign w_idle       = (r_state == S_IDLE);
  assign w_any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign w_ld_ok      = w_idle & take_action_ocimem_a & ~jdo[36];
  assign w_ld_rsvd    = w_idle & take_action_ocimem_a & jdo[36];
  assign w_ld_rd      = w_ld_ok & jdo[35];
  assign w_wr         = w_idle & ~take_action_ocimem_a & take_action_ocimem_b;
  assign w_rd         = w_idle & ~take_action_ocimem_a & ~take_action_ocimem_b &
                        take_no_action_ocimem_a;
  assign w_busy_err   = ~w_idle & w_any_strobe;
  assign w_ram_we     = w_wr & ~reset;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_rd || w_ld_rd) w_next_state = S_RD;
      S_RD:    w_next_state = S_CAP;
      S_CAP:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    monitor_ready   = (r_state == S_IDLE);
    w_ram_addr      = cpu_address;
    if ((r_state == S_RD) || w_wr) w_ram_addr = r_mon_addr;
    cpu_waitrequest = cpu_read & (w_any_strobe | (r_state != S_IDLE));
    w_cpu_accept    = cpu_read & ~cpu_waitrequest;
  end

  // Debug RAM: contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_addr] <= jdo[34:3];
    r_ram_q <= r_mem[w_ram_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mon_addr  <= '0;
      r_error     <= 1'b0;
      r_no_inc    <= 1'b0;
      r_mon_dreg  <= '0;
      r_cpu_pend  <= 1'b0;
      r_cpu_valid <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      if (w_ld_ok)
        r_mon_addr <= jdo[ADDR_W+1:2];
      else if (w_wr || ((r_state == S_CAP) && !r_no_inc))
        r_mon_addr <= r_mon_addr + ADDR_W'(1);

      if (w_ld_ok)                      r_error <= 1'b0;
      else if (w_ld_rsvd || w_busy_err) r_error <= 1'b1;

      if (w_rd)         r_no_inc <= 1'b0;
      else if (w_ld_rd) r_no_inc <= 1'b1;

      if (r_state == S_CAP) r_mon_dreg <= r_ram_q;

      // CPU read: RAM addressed on accept, data registered one cycle later.
      r_cpu_pend  <= w_cpu_accept;
      r_cpu_valid <= r_cpu_pend;
      if (r_cpu_pend) r_cpu_rdata <= r_ram_q;
    end
  end

  assign MonDReg           = r_mon_dreg;
  assign monitor_error     = r_error;
  assign cpu_readdata      = r_cpu_rdata;
  assign cpu_readdatavalid = r_cpu_valid;

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Scoreboard bench for nios2_debug_ocimem_ctrl: directed debug/CPU traffic,
// expected results queued at issue time and checked by a negedge monitor.
module tb_nios2_debug_ocimem_ctrl;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [7:0]  cpu_address;
  logic        cpu_read;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  addr;
  } dbg_t;

  dbg_t        dbg_q[$];
  logic [31:0] cpu_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        prev_ready = 1'b1;

  nios2_debug_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_waitrequest         (cpu_waitrequest),
    .cpu_readdata            (cpu_readdata),
    .cpu_readdatavalid       (cpu_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Monitor: debug result on each rising monitor_ready, CPU data on each valid.
  always @(negedge clk) begin
    if (reset) begin
      prev_ready = 1'b1;
    end else begin
      if (cpu_readdatavalid) begin
        if (cpu_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL cpu_unexpected_valid: got valid with %h, required no valid", cpu_readdata);
        end else begin
          chk("cpu_readdata", cpu_readdata, cpu_q.pop_front());
        end
      end
      if (monitor_ready && !prev_ready) begin
        if (dbg_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL dbg_unexpected_done: got read completion MonDReg %h, required none", MonDReg);
        end else begin
          dbg_t e;
          e = dbg_q.pop_front();
          chk("MonDReg", MonDReg, e.data);
          chk("mon_addr_after_read", 32'(dut.r_mon_addr), 32'(e.addr));
        end
      end
      prev_ready = monitor_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] w, input logic rd, input logic rsvd);
    jdo = '0;
    jdo[9:2] = w;
    jdo[35] = rd;
    jdo[36] = rsvd;
    take_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
  endtask

  task automatic write(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    #1 chk("wr_ready_high", 32'(monitor_ready), 32'd1);
    step();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
  endtask

  // mode 0: read strobe; mode 1: address load with immediate read.
  task automatic do_read(input int mode, input logic [7:0] w,
                         input logic [31:0] d, input logic [7:0] a);
    dbg_q.push_back('{data: d, addr: a});
    if (mode == 0) begin
      take_no_action_ocimem_a = 1'b1;
      step();
      take_no_action_ocimem_a = 1'b0;
    end else begin
      load(w, 1'b1, 1'b0);
    end
    chk("rd_ready_rd", 32'(monitor_ready), 32'd0);
    step();
    chk("rd_ready_cap", 32'(monitor_ready), 32'd0);
    step();
    chk("rd_ready_idle", 32'(monitor_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    cpu_address = '0;
    cpu_read = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_MonDReg", MonDReg, 32'h0);
    chk("rst_ready", 32'(monitor_ready), 32'd1);
    chk("rst_error", 32'(monitor_error), 32'd0);
    chk("rst_cpu_valid", 32'(cpu_readdatavalid), 32'd0);
    chk("rst_cpu_data", cpu_readdata, 32'h0);
    chk("rst_mon_addr", 32'(dut.r_mon_addr), 32'd0);

    // Write then read back at word 4.
    load(8'd4, 1'b0, 1'b0);
    chk("ld_addr4", 32'(dut.r_mon_addr), 32'd4);
    write(32'hDEADBEEF);
    chk("wr_inc", 32'(dut.r_mon_addr), 32'd5);
    load(8'd4, 1'b0, 1'b0);
    do_read(0, 8'd0, 32'hDEADBEEF, 8'd5);
    chk("rd_error_clear", 32'(monitor_error), 32'd0);

    // Write immediately followed by a load-and-read of the same word.
    load(8'd10, 1'b0, 1'b0);
    write(32'h0BADF00D);
    do_read(1, 8'd10, 32'h0BADF00D, 8'd10);
    do_read(0, 8'd0, 32'h0BADF00D, 8'd11);

    // Wrap-around at the top of the RAM.
    load(8'd255, 1'b0, 1'b0);
    write(32'h11111111);
    write(32'h22222222);
    chk("wrap_wr_addr", 32'(dut.r_mon_addr), 32'd1);
    load(8'd255, 1'b0, 1'b0);
    do_read(0, 8'd0, 32'h11111111, 8'd0);
    do_read(0, 8'd0, 32'h22222222, 8'd1);

    // Busy: second read strobe in RD, write strobe in CAP.
    load(8'd4, 1'b0, 1'b0);
    dbg_q.push_back('{data: 32'hDEADBEEF, addr: 8'd5});
    take_no_action_ocimem_a = 1'b1;
    step();
    step();
    take_no_action_ocimem_a = 1'b0;
    chk("busy_err_set", 32'(monitor_error), 32'd1);
    jdo[34:3] = 32'h55555555;
    take_action_ocimem_b = 1'b1;
    step();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    chk("busy_ready", 32'(monitor_ready), 32'd1);
    chk("busy_addr_once", 32'(dut.r_mon_addr), 32'd5);
    step();
    load(8'd4, 1'b0, 1'b0);
    chk("busy_err_clear", 32'(monitor_error), 32'd0);
    do_read(0, 8'd0, 32'hDEADBEEF, 8'd5);

    // Simultaneous strobes.
    jdo = '0;
    jdo[9:2] = 8'd20;
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
    chk("prio_a_addr", 32'(dut.r_mon_addr), 32'd20);
    chk("prio_a_ready", 32'(monitor_ready), 32'd1);
    chk("prio_a_err", 32'(monitor_error), 32'd0);
    jdo = '0;
    jdo[34:3] = 32'hA5A55A5A;
    step();
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = '0;
    chk("prio_b_addr", 32'(dut.r_mon_addr), 32'd21);
    chk("prio_b_ready", 32'(monitor_ready), 32'd1);
    chk("prio_b_err", 32'(monitor_error), 32'd0);
    do_read(1, 8'd20, 32'hA5A55A5A, 8'd20);

    // Reserved address-load encoding.
    load(8'd4, 1'b0, 1'b0);
    load(8'd9, 1'b1, 1'b1);
    chk("rsvd_err", 32'(monitor_error), 32'd1);
    chk("rsvd_addr", 32'(dut.r_mon_addr), 32'd4);
    chk("rsvd_no_read", 32'(monitor_ready), 32'd1);
    load(8'd4, 1'b0, 1'b0);
    chk("rsvd_err_clear", 32'(monitor_error), 32'd0);

    // CPU read held across a debug read.
    load(8'd255, 1'b0, 1'b0);
    dbg_q.push_back('{data: 32'h11111111, addr: 8'd0});
    cpu_address = 8'd4;
    cpu_read = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    #1 chk("cpu_wait_strobe", 32'(cpu_waitrequest), 32'd1);
    step();
    take_no_action_ocimem_a = 1'b0;
    #1 chk("cpu_wait_rd", 32'(cpu_waitrequest), 32'd1);
    step();
    chk("cpu_wait_cap", 32'(cpu_waitrequest), 32'd1);
    step();
    chk("cpu_wait_idle", 32'(cpu_waitrequest), 32'd0);
    cpu_q.push_back(32'hDEADBEEF);
    step();
    cpu_read = 1'b0;
    step(); step(); step();
    chk("cpu_MonDReg_kept", MonDReg, 32'h11111111);
    chk("cpu_addr_kept", 32'(dut.r_mon_addr), 32'd0);

    // Back-to-back CPU reads.
    cpu_address = 8'd255;
    cpu_read = 1'b1;
    #1 chk("cpu_b2b_wait", 32'(cpu_waitrequest), 32'd0);
    cpu_q.push_back(32'h11111111);
    step();
    cpu_address = 8'd4;
    cpu_q.push_back(32'hDEADBEEF);
    step();
    cpu_read = 1'b0;
    step(); step(); step();

    // Reset with a CPU read in flight.
    cpu_address = 8'd4;
    cpu_read = 1'b1;
    step();
    cpu_read = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step(); step(); step();

    // Reset in the RD cycle of a debug read.
    load(8'd4, 1'b0, 1'b0);
    take_no_action_ocimem_a = 1'b1;
    step();
    take_no_action_ocimem_a = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rstrd_ready", 32'(monitor_ready), 32'd1);
    chk("rstrd_MonDReg", MonDReg, 32'h0);
    chk("rstrd_addr", 32'(dut.r_mon_addr), 32'd0);
    chk("rstrd_valid", 32'(cpu_readdatavalid), 32'd0);
    step(); step(); step();
    chk("rstrd_MonDReg_late", MonDReg, 32'h0);
    chk("rstrd_addr_late", 32'(dut.r_mon_addr), 32'd0);

    chk("dbg_queue_drained", 32'(dbg_q.size()), 32'd0);
    chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
